// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: datapath width, default
// reset PC and the controller state encoding.
package icache_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_MISS  = 1'b1
  } state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding memory read and a jump-redirect path from the ROB.
module icache
  import icache_pkg::*;
#(
  parameter int              ICACHE_LINES = 64,
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            if_not_full,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_data,
  output logic            have_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc_out
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  state_t            r_state, w_state_nx;
  logic [XLEN-1:0]   r_pc, w_pc_nx;
  logic              r_discard, w_discard_nx;

  logic [ICACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [XLEN-1:0]         r_data [ICACHE_LINES];

  logic              w_mem_req_nx;
  logic [XLEN-1:0]   w_mem_addr_nx;
  logic              w_have_nx;
  logic [XLEN-1:0]   w_instr_nx, w_instr_pc_nx;
  logic              w_fill;

  logic [IDX_W-1:0]  w_idx, w_fidx;
  logic [TAG_W-1:0]  w_tag, w_ftag;
  logic              w_hit;

  assign w_idx  = r_pc[IDX_W+1:2];
  assign w_tag  = r_pc[XLEN-1:IDX_W+2];
  assign w_fidx = mem_addr[IDX_W+1:2];
  assign w_ftag = mem_addr[XLEN-1:IDX_W+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_discard_nx  = r_discard;
    w_mem_req_nx  = mem_req;
    w_mem_addr_nx = mem_addr;
    w_have_nx     = 1'b0;
    w_instr_nx    = instr_out;
    w_instr_pc_nx = instr_pc_out;
    w_fill        = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (jump_flag) begin
          w_pc_nx = jump_pc;
        end else if (if_not_full) begin
          if (w_hit) begin
            w_have_nx     = 1'b1;
            w_instr_nx    = r_data[w_idx];
            w_instr_pc_nx = r_pc;
            w_pc_nx       = r_pc + 32'd4;
          end else begin
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = r_pc;
            w_state_nx    = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mem_done) begin
          w_fill       = 1'b1;
          w_mem_req_nx = 1'b0;
          w_state_nx   = S_FETCH;
          w_discard_nx = 1'b0;
          // A redirect seen during or with the fill makes the word wrong-path:
          // keep it in the cache but do not hand it to the fetch queue.
          if (r_discard || jump_flag) begin
            w_pc_nx = jump_flag ? jump_pc : r_pc;
          end else begin
            w_have_nx     = 1'b1;
            w_instr_nx    = mem_data;
            w_instr_pc_nx = mem_addr;
            w_pc_nx       = r_pc + 32'd4;
          end
        end else if (jump_flag) begin
          w_pc_nx      = jump_pc;
          w_discard_nx = 1'b1;
        end
      end
      default: w_state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      r_state <= S_FETCH;
    else if (rdy_in) r_state <= w_state_nx;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc         <= RESET_PC;
      r_discard    <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      have_out     <= 1'b0;
      instr_out    <= '0;
      instr_pc_out <= '0;
    end else if (rdy_in) begin
      r_pc         <= w_pc_nx;
      r_discard    <= w_discard_nx;
      mem_req      <= w_mem_req_nx;
      mem_addr     <= w_mem_addr_nx;
      have_out     <= w_have_nx;
      instr_out    <= w_instr_nx;
      instr_pc_out <= w_instr_pc_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)                  r_valid         <= '0;
    else if (rdy_in && w_fill)   r_valid[w_fidx] <= 1'b1;
  end

  // Tag/data storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_fill) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: a line-residency reference model
// predicts deliveries, and a negedge monitor compares them as they appear.
module tb_icache;

  localparam int LINES = 64;
  localparam int IW    = 6;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_not_full = 1'b0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;
  logic        have_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;

  always #5 clk_in = ~clk_in;

  icache #(.ICACHE_LINES(LINES), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_not_full(if_not_full), .jump_flag(jump_flag), .jump_pc(jump_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
    .mem_data(mem_data), .have_out(have_out), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  // Reference model: which word address lives in each slot, plus the
  // architectural fetch PC and the single outstanding read.
  logic [31:0] m_pc = '0;
  logic [31:0] m_req = '0;
  bit          m_busy = 0, m_disc = 0, m_was_rst = 0;
  int          m_wait = 0, m_delay = -1;
  logic [31:0] m_line [LINES];
  bit          m_lv   [LINES];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a[IW+1:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (have_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_have_out: got pc %h expected no output", instr_pc_out);
      end else begin
        e = sb.pop_front();
        chk("instr_pc_out", instr_pc_out, e.pc);
        chk("instr_out", instr_out, e.ins);
      end
    end
  end

  task automatic cycle(input bit rst, input bit jmp, input logic [31:0] jpc,
                       input bit nf, input bit fdone);
    bit          done;
    logic [31:0] dat;
    @(negedge clk_in);
    #1;
    if (m_was_rst) begin
      chk("reset_have_out", {31'b0, have_out}, 32'h0);
      chk("reset_instr_out", instr_out, 32'h0);
      chk("reset_instr_pc_out", instr_pc_out, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
    end
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
    if (m_busy) chk("mem_addr", mem_addr, m_req);
    done = fdone;
    dat  = $urandom();
    if (m_busy && !rst) begin
      if (m_wait == 0) begin
        done = 1;
        dat  = memw(m_req);
      end else m_wait--;
    end
    rst_in = rst; jump_flag = jmp; jump_pc = jpc; if_not_full = nf;
    mem_done = done; mem_data = dat;
    m_was_rst = rst;
    if (rst) begin
      m_pc = 32'h0; m_busy = 0; m_disc = 0;
      foreach (m_lv[i]) m_lv[i] = 0;
    end else if (!m_busy) begin
      if (jmp) m_pc = jpc;
      else if (nf) begin
        if (m_lv[idx(m_pc)] && m_line[idx(m_pc)] == m_pc) begin
          sb.push_back('{m_pc, memw(m_pc)});
          m_pc += 32'd4;
        end else begin
          m_busy = 1;
          m_req  = m_pc;
          m_wait = (m_delay >= 0) ? m_delay : int'($urandom_range(0, 4));
        end
      end
    end else if (done) begin
      m_lv[idx(m_req)]   = 1;
      m_line[idx(m_req)] = m_req;
      m_busy = 0;
      if (!m_disc && !jmp) begin
        sb.push_back('{m_req, memw(m_req)});
        m_pc = m_req + 32'd4;
      end else if (jmp) m_pc = jpc;
      m_disc = 0;
    end else if (jmp) begin
      m_pc   = jpc;
      m_disc = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_busy; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic fetch_to(input logic [31:0] pc, input int n);
    cycle(0, 1, pc, 0, 0);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0, 1, 0);
      drain();
    end
  endtask

  logic [31:0] tgt;

  initial begin
    m_delay = 3;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // cold start: single miss at PC 0
    cycle(0, 0, 0, 1, 0);
    drain();
    cycle(0, 0, 0, 0, 0);
    // two passes over 0x0..0xC; the second must be all hits
    fetch_to(32'h0, 4);
    cycle(0, 1, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    // queue full on a hit, then release
    cycle(0, 1, 32'h4, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    // redirect mid-miss at 0x8
    cycle(1, 0, 0, 0, 0);
    m_delay = 4;
    cycle(0, 1, 32'h8, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h100, 0, 0);
    drain();
    cycle(0, 0, 0, 1, 0);
    drain();
    fetch_to(32'h8, 1);
    // jump coincident with mem_done, then jump on a hit cycle
    cycle(0, 1, 32'h20, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 40 && m_busy; i++) cycle(0, (m_wait == 0), 32'h8, 0, 0);
    cycle(0, 1, 32'h8, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    // aliasing slot 0 and PC wrap
    m_delay = 1;
    fetch_to(32'h0, 1);
    fetch_to(32'h100, 1);
    fetch_to(32'h0, 1);
    fetch_to(32'hFFFF_FFFC, 1);
    fetch_to(32'hFFFF_FFFC, 2);
    // reset during a miss, then a stray mem_done
    cycle(0, 1, 32'h40, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    // random traffic
    m_delay = -1;
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 2))
        0:       tgt = 32'($urandom_range(0, 15)) * 32'd4;
        1:       tgt = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
        default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      endcase
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), tgt,
            ($urandom_range(0, 3) != 0), 0);
    end
    drain();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
